// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO/shifter: takes 8-pixel tile rows from the fetcher, applies
// SCX fine-scroll discard, maps through BGP and emits one registered pixel per dot.
module bg_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int LINE_W = 160
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_full,
    input  logic [7:0][1:0] fetch_pixels,
    output logic            fetch_ack,
    input  logic [2:0]      scx_fine,
    input  logic            bg_ena,
    input  logic [7:0]      bgp,
    output logic            pix_valid,
    output logic [1:0]      pix_color,
    output logic [7:0]      lx,
    output logic            line_done
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    fifo_reg  [DEPTH];
    logic [1:0]    fifo_next [DEPTH];
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [2:0]    discard_reg;
    logic [7:0]    lx_reg;
    logic          pix_valid_reg;
    logic [1:0]    pix_color_reg;
    logic          line_done_reg;

    logic          pop;
    logic          load;
    logic          emit;
    logic [CW-1:0] base;
    logic [1:0]    color_idx;
    logic [1:0]    shade;

    assign pop  = (count_reg != '0) & ~line_done_reg & ~rst;
    assign load = fetch_full & (count_reg <= CW'(8)) & ~line_done_reg & ~rst;
    assign fetch_ack = load;

    // A same-cycle pop shifts everything down one slot, so the new row lands one lower.
    assign base = count_reg - CW'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [CW-1:0] offset;
            logic          load_here;
            logic [1:0]    shifted;

            assign offset    = CW'(gi) - base;
            assign load_here = load & (CW'(gi) >= base) & (offset < CW'(8));

            if (gi < DEPTH - 1) begin : g_mid
                assign shifted = pop ? fifo_reg[gi+1] : fifo_reg[gi];
            end else begin : g_tail
                assign shifted = fifo_reg[gi];
            end

            // Leftmost pixel (index 7) goes to the lowest slot of the row.
            assign fifo_next[gi] = load_here ? fetch_pixels[~offset[2:0]] : shifted;
        end
    endgenerate

    assign count_next = count_reg + (load ? CW'(8) : CW'(0)) - CW'(pop);

    assign emit      = pop & (discard_reg == 3'd0);
    assign color_idx = bg_ena ? fifo_reg[0] : 2'd0;
    assign shade     = bgp[{color_idx, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_reg[i] <= fifo_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            discard_reg   <= scx_fine;
            lx_reg        <= '0;
            pix_valid_reg <= 1'b0;
            pix_color_reg <= 2'd0;
            line_done_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            pix_valid_reg <= emit;
            if (pop && discard_reg != 3'd0) begin
                discard_reg <= discard_reg - 3'd1;
            end
            if (emit) begin
                pix_color_reg <= shade;
                lx_reg        <= lx_reg + 8'd1;
                if (lx_reg == 8'(LINE_W - 1)) begin
                    line_done_reg <= 1'b1;
                end
            end
        end
    end

    assign pix_valid = pix_valid_reg;
    assign pix_color = pix_color_reg;
    assign lx        = lx_reg;
    assign line_done = line_done_reg;

endmodule
